// File: rtl/quad_decoder_pkg.sv
// Shared types and constants for the quadrature decoder: phase encoding,
// up-sequence successor helper and the filter length ceiling.
package quad_decoder_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_01 = 2'b01;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_10 = 2'b10;

    localparam int FILT_LEN_MAX = 15;

    // Successor of a phase along the up sequence 00->01->11->10->00.
    function automatic phase_t next_up(input phase_t p);
        phase_t n;
        case (p)
            PH_00:   n = PH_01;
            PH_01:   n = PH_11;
            PH_11:   n = PH_10;
            PH_10:   n = PH_00;
            default: n = PH_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qdec_chan_filt.sv
// One quadrature channel: 2-flop synchronizer followed by a run-length
// glitch filter (present only when QUAD_DECODER_FILTER_EN is defined).
module qdec_chan_filt
    import quad_decoder_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic valid
);

    logic       sync1_r;
    logic       sync2_r;
    logic [1:0] svld_r;

    // Synchronizer chain plus a shift marker telling when sync2_r holds real pin data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            svld_r  <= 2'b00;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            svld_r  <= {svld_r[0], 1'b1};
        end
    end

`ifdef QUAD_DECODER_FILTER_EN
    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic [3:0] cnt_r;
    logic       filt_r;
    logic       fvld_r;

    // The first valid synchronized sample seeds the level directly; after that a
    // level change needs FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r  <= 4'd0;
            filt_r <= 1'b0;
            fvld_r <= 1'b0;
        end else if (!fvld_r) begin
            cnt_r <= 4'd0;
            if (svld_r[1]) begin
                filt_r <= sync2_r;
                fvld_r <= 1'b1;
            end else begin
                filt_r <= filt_r;
                fvld_r <= fvld_r;
            end
        end else if (sync2_r != filt_r) begin
            if (cnt_r >= CNT_LAST) begin
                filt_r <= sync2_r;
                cnt_r  <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end else begin
            cnt_r <= 4'd0;
        end
    end

    assign level = filt_r;
    assign valid = fvld_r;
`else
    assign level = sync2_r;
    assign valid = svld_r[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature step decoder producing count-enable/direction for an up/down
// counter. Optional glitch filter: define QUAD_DECODER_FILTER_EN.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       enable,
    input  logic       clr_err,
    output logic       cen,
    output logic       up_dn,
    output logic       err,
    output logic [1:0] phase
);

    localparam int FILT_EFF = (FILT_LEN < 1) ? 1 :
                              (FILT_LEN > FILT_LEN_MAX) ? FILT_LEN_MAX : FILT_LEN;

    logic   a_filt_s, b_filt_s;
    logic   a_vld_s, b_vld_s;
    logic   both_vld_s;
    phase_t cur_s;
    logic   step_up_s, step_dn_s, illegal_s;

    logic   init_r;
    phase_t phase_r;
    logic   cen_r, up_dn_r, err_r;

    qdec_chan_filt #(.FILT_LEN(FILT_EFF)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .din   (a_in),
        .level (a_filt_s),
        .valid (a_vld_s)
    );

    qdec_chan_filt #(.FILT_LEN(FILT_EFF)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .din   (b_in),
        .level (b_filt_s),
        .valid (b_vld_s)
    );

    // Classify the change between the registered phase and the filtered inputs.
    always_comb begin
        step_up_s  = 1'b0;
        step_dn_s  = 1'b0;
        illegal_s  = 1'b0;
        cur_s      = {a_filt_s, b_filt_s};
        both_vld_s = a_vld_s & b_vld_s;
        if (both_vld_s && init_r && (cur_s != phase_r)) begin
            if (cur_s == next_up(phase_r)) begin
                step_up_s = 1'b1;
            end else if (next_up(cur_s) == phase_r) begin
                step_dn_s = 1'b1;
            end else begin
                illegal_s = 1'b1;
            end
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Phase tracking, init flag, registered count-enable, direction and sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            init_r  <= 1'b0;
            phase_r <= PH_00;
            cen_r   <= 1'b0;
            up_dn_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (both_vld_s) begin
                init_r  <= 1'b1;
                phase_r <= cur_s;
            end else begin
                init_r  <= init_r;
                phase_r <= phase_r;
            end

            cen_r <= enable & (step_up_s | step_dn_s);

            // Direction only follows steps that actually reach the counter.
            if (enable && step_up_s) begin
                up_dn_r <= 1'b1;
            end else if (enable && step_dn_s) begin
                up_dn_r <= 1'b0;
            end else begin
                up_dn_r <= up_dn_r;
            end

            // A new illegal jump wins over a simultaneous clear.
            if (illegal_s) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign cen   = cen_r;
    assign up_dn = up_dn_r;
    assign err   = err_r;
    assign phase = phase_r;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: vector table, corner sequences and
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_quad_decoder;

    localparam int FL = 3;
`ifdef QUAD_DECODER_FILTER_EN
    localparam int LAT        = 2 + FL;
    localparam int GLITCH_CEN = 0;
`else
    localparam int LAT        = 2;
    localparam int GLITCH_CEN = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_in = 1'b0, b_in = 1'b0;
    logic       enable = 1'b1, clr_err = 1'b0;
    logic       cen, up_dn, err;
    logic [1:0] phase;

    int n_chk  = 0;
    int n_pass = 0;

    quad_decoder #(.FILT_LEN(FL)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .enable  (enable),
        .clr_err (clr_err),
        .cen     (cen),
        .up_dn   (up_dn),
        .err     (err),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic       hist_a[$];
    logic       hist_b[$];
    logic [1:0] m_f   = 2'b00;
    bit         m_fv  = 1'b0;
    logic [1:0] m_ph  = 2'b00;
    bit         m_init = 1'b0;
    logic       m_up  = 1'b0;
    logic       m_err = 1'b0;
    logic       m_cen = 1'b0;

    // Position of a phase along the up cycle; a step is +1 (up), -1 (down) or 2 (illegal).
    function automatic int pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

`ifdef QUAD_DECODER_FILTER_EN
    // Level flips once the last FL filtered-era samples all disagree with it.
    function automatic logic filt_bit(input bit is_a, input int k, input logic cur);
        int lo;
        logic s;
        lo = k - 1 - FL;
        if (lo < 1) return cur;
        for (int j = lo; j <= k - 2; j++) begin
            s = is_a ? hist_a[j] : hist_b[j];
            if (s == cur) return cur;
        end
        return ~cur;
    endfunction
`endif

    function automatic void model_edge(input logic r, input logic a, input logic b,
                                       input logic en, input logic clr);
        int  k, d;
        bit  illegal;
        if (!r) begin
            hist_a.delete(); hist_b.delete();
            m_f = 2'b00; m_fv = 1'b0; m_ph = 2'b00; m_init = 1'b0;
            m_up = 1'b0; m_err = 1'b0; m_cen = 1'b0;
            return;
        end
        hist_a.push_back(a);
        hist_b.push_back(b);
        k = hist_a.size() - 1;
        m_cen   = 1'b0;
        illegal = 1'b0;
        if (m_fv) begin
            if (!m_init) begin
                m_ph = m_f; m_init = 1'b1;
            end else if (m_f != m_ph) begin
                d = (pos(m_f) - pos(m_ph) + 4) % 4;
                if (d == 2) illegal = 1'b1;
                else if (en) begin
                    m_cen = 1'b1;
                    m_up  = (d == 1);
                end
                m_ph = m_f;
            end
        end
        if (illegal) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
`ifdef QUAD_DECODER_FILTER_EN
        if (k == 2) begin
            m_f = {hist_a[0], hist_b[0]}; m_fv = 1'b1;
        end else if (k >= 3) begin
            m_f[1] = filt_bit(1'b1, k, m_f[1]);
            m_f[0] = filt_bit(1'b0, k, m_f[0]);
        end
`else
        if (k >= 1) begin
            m_f = {hist_a[k-1], hist_b[k-1]}; m_fv = 1'b1;
        end
`endif
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, compare just after.
    task automatic tick(input logic r, input logic a, input logic b,
                        input logic en, input logic clr);
        @(negedge clk);
        reset = r; a_in = a; b_in = b; enable = en; clr_err = clr;
        @(posedge clk);
        model_edge(r, a, b, en, clr);
        #1;
        check("model_cen",   int'(cen),   int'(m_cen));
        check("model_up_dn", int'(up_dn), int'(m_up));
        check("model_err",   int'(err),   int'(m_err));
        check("model_phase", int'(phase), int'(m_ph));
    endtask

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       clr;
        int         hold;
        logic [1:0] ph;
        int         ncen;
        logic       up;
        logic       err;
    } vec_t;

    vec_t tbl[14];
    int   cnt, first_i, hold_left;
    logic [1:0] rab;
    logic ren, rclr, rrst;

    initial begin
        tbl[0]  = '{2'b00, 1'b1, 1'b0, 8, 2'b00, 0, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 1'b1, 1'b0, 8, 2'b01, 1, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 8, 2'b11, 1, 1'b1, 1'b0};
        tbl[3]  = '{2'b10, 1'b1, 1'b0, 8, 2'b10, 1, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 1'b1, 1'b0, 8, 2'b00, 1, 1'b1, 1'b0};
        tbl[5]  = '{2'b10, 1'b1, 1'b0, 8, 2'b10, 1, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 8, 2'b11, 1, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b1, 1'b0, 8, 2'b01, 1, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 1'b1, 1'b0, 8, 2'b00, 1, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 1'b1, 1'b0, 8, 2'b11, 0, 1'b0, 1'b1};
        tbl[10] = '{2'b11, 1'b1, 1'b1, 8, 2'b11, 0, 1'b0, 1'b0};
        tbl[11] = '{2'b01, 1'b0, 1'b0, 8, 2'b01, 0, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 8, 2'b00, 0, 1'b0, 1'b0};
        tbl[13] = '{2'b01, 1'b1, 1'b0, 8, 2'b01, 1, 1'b1, 1'b0};

        // Reset with pins at 00, outputs must be cleared.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_cen", int'(cen), 0);
        check("reset_up_dn", int'(up_dn), 0);
        check("reset_err", int'(err), 0);
        check("reset_phase", int'(phase), 0);

        // Vector table.
        for (int v = 0; v < 14; v++) begin
            cnt = 0; first_i = -1;
            for (int i = 0; i < tbl[v].hold; i++) begin
                tick(1'b1, tbl[v].ab[1], tbl[v].ab[0], tbl[v].en, tbl[v].clr);
                if (cen) begin
                    cnt++;
                    if (first_i < 0) first_i = i;
                end
            end
            check($sformatf("vec%0d_ncen", v), cnt, tbl[v].ncen);
            if (tbl[v].ncen > 0) check($sformatf("vec%0d_latency", v), first_i, LAT);
            check($sformatf("vec%0d_phase", v), int'(phase), int'(tbl[v].ph));
            check($sformatf("vec%0d_up_dn", v), int'(up_dn), int'(tbl[v].up));
            check($sformatf("vec%0d_err", v), int'(err), int'(tbl[v].err));
        end

        // Glitches on A (1 and 2 clocks) starting from a settled 00.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int g = 1; g <= 2; g++) begin
            cnt = 0;
            for (int i = 0; i < g; i++) begin
                tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
                if (cen) cnt++;
            end
            for (int i = 0; i < 10; i++) begin
                tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                if (cen) cnt++;
            end
            check($sformatf("glitch%0d_ncen", g), cnt, GLITCH_CEN);
            check($sformatf("glitch%0d_phase", g), int'(phase), 0);
            check($sformatf("glitch%0d_err", g), int'(err), 0);
        end

        // Illegal jump 00->11, then clear coincident with a second illegal jump.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("jump_err_set", int'(err), 1);
        check("jump_phase", int'(phase), 3);
        for (int i = 0; i <= LAT; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, (i == LAT) ? 1'b1 : 1'b0);
        check("clr_vs_illegal_err", int'(err), 1);
        check("clr_vs_illegal_phase", int'(phase), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_err_clears", int'(err), 0);

        // Pins held at 11 through reset release.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset11_phase_in_reset", int'(phase), 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            if (cen) cnt++;
        end
        check("reset11_ncen", cnt, 0);
        check("reset11_phase", int'(phase), 3);
        check("reset11_err", int'(err), 0);

        // Reset in the middle of a pending step discards it.
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            if (cen) cnt++;
        end
        check("midreset_ncen", cnt, 0);
        check("midreset_phase", int'(phase), 2);
        check("midreset_err", int'(err), 0);

        // Randomized traffic against the model.
        hold_left = 0;
        rab = 2'b10; ren = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (hold_left == 0) begin
                rab = 2'($urandom_range(0, 3));
                hold_left = $urandom_range(1, 7);
                ren = ($urandom_range(0, 7) != 0);
            end
            hold_left--;
            rclr = ($urandom_range(0, 7) == 0);
            rrst = ($urandom_range(0, 299) != 0);
            tick(rrst, rab[1], rab[0], ren, rclr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
